// File: rtl/secure_encrypt_ctrl.sv
// secure_encrypt_ctrl: streams a message of msg_len words through a per-bit
// key transform. The key rotates left by one bit after every accepted word.
// There is a one-word registered output stage with valid/ready backpressure.
module secure_encrypt_ctrl #(
    parameter int N  = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_load,
    input  logic [N-1:0]  cfg_key,
    input  logic          start,
    input  logic [LW-1:0] msg_len,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  key_q, key_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [LW-1:0] word_cnt_q, word_cnt_d;
    logic [LW-1:0] remain_q, remain_d;

    logic          in_ready_c;
    logic          accept_c;
    logic          out_xfer_c;

    // Key bits that are set force the output bit high. All other bits pass the plaintext through.
    function automatic logic [N-1:0] xform(input logic [N-1:0] d, input logic [N-1:0] k);
        return d | k;
    endfunction

    // Handshake qualifiers shared by the FSM and datapath
    always_comb begin
        in_ready_c = (state_q == S_RUN) && (remain_q != '0) && (!out_valid_q || out_ready);
        accept_c   = in_valid && in_ready_c;
        out_xfer_c = out_valid_q && out_ready;
    end

    // Next-state logic for the message FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (msg_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (accept_c && (remain_q == LW'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: key register, output stage, counters
    always_comb begin
        key_d       = key_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        word_cnt_d  = word_cnt_q;
        remain_d    = remain_q;

        if (state_q == S_IDLE) begin
            if (key_load) begin
                key_d = cfg_key;
            end
            if (start) begin
                word_cnt_d = '0;
                remain_d   = msg_len;
            end
        end

        // A transfer frees the stage. An accept in the same cycle refills it, so there is no bubble.
        if (out_xfer_c) begin
            out_valid_d = 1'b0;
        end
        if (accept_c) begin
            out_data_d  = xform(in_data, key_q);
            out_valid_d = 1'b1;
            key_d       = {key_q[N-2:0], key_q[N-1]};
            word_cnt_d  = word_cnt_q + LW'(1);
            remain_d    = remain_q - LW'(1);
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
            remain_q    <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
            remain_q    <= remain_d;
        end
    end

    // Output mapping
    always_comb begin
        in_ready  = in_ready_c;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        word_cnt  = word_cnt_q;
    end

endmodule

// File: tb/tb_secure_encrypt_ctrl.sv
// Scoreboard bench for secure_encrypt_ctrl.
module tb_secure_encrypt_ctrl;

    localparam int N  = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_load;
    logic [N-1:0]  cfg_key;
    logic          start;
    logic [LW-1:0] msg_len;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [N-1:0]  out_data;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [LW-1:0] word_cnt;

    secure_encrypt_ctrl #(.N(N), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .cfg_key   (cfg_key),
        .start     (start),
        .msg_len   (msg_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference transform, written bit by bit
    function automatic logic [N-1:0] ref_t(input logic [N-1:0] d, input logic [N-1:0] k);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = k[i] ? 1'b1 : d[i];
        end
        return r;
    endfunction

    logic [N-1:0] sb_q[$];
    logic [N-1:0] out_log[$];
    int           acc_cyc[$];
    int           cyc = 0;
    int           done_cnt = 0;
    logic [N-1:0] key_m = '0;
    logic [N-1:0] sb_exp;
    logic [N-1:0] msg[8];

    always @(posedge clk) cyc++;

    // Monitor: pop and compare on output transfers; push expectations on accepts
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            key_m = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", sb_q.size(), 1);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check_eq("out_data", out_data, sb_exp);
                end
                out_log.push_back(out_data);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_t(in_data, key_m));
                key_m = {key_m[N-2:0], key_m[N-1]};
                acc_cyc.push_back(cyc);
            end
            if (key_load && !busy && !done) key_m = cfg_key;
            if (done) done_cnt++;
        end
    end

    task automatic wait_ready();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 50);
        check_eq("in_ready_timeout", in_ready, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 50);
        check_eq("done_timeout", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input int len, input logic ld, input logic [N-1:0] key);
        @(posedge clk);
        #1;
        start    = 1'b1;
        msg_len  = len[LW-1:0];
        key_load = ld;
        cfg_key  = key;
        @(posedge clk);
        #1;
        start    = 1'b0;
        key_load = 1'b0;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = msg[i];
            wait_ready();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done();
    endtask

    int d0;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_load = 1'b0; cfg_key = '0; start = 1'b0; msg_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_word_cnt", word_cnt, 0);
        rst = 1'b0;

        // Basic two-word message, key_load together with start
        out_log.delete(); d0 = done_cnt; out_ready = 1'b1;
        msg[0] = 8'hA0; msg[1] = 8'h00;
        run_msg(2, 1'b1, 8'h0F);
        check_eq("basic_n", out_log.size(), 2);
        check_eq("basic_w0", out_log[0], 8'hAF);
        check_eq("basic_w1", out_log[1], 8'h1E);
        check_eq("basic_done_cnt", done_cnt - d0, 1);
        check_eq("basic_word_cnt", word_cnt, 2);

        // Backpressure: word held for 5 cycles with out_ready low
        out_log.delete(); out_ready = 1'b0;
        msg[0] = 8'h40; msg[1] = 8'h00;
        fork
            run_msg(2, 1'b1, 8'h01);
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!out_valid && t < 50);
                check_eq("stall_valid0", out_valid, 1);
                repeat (5) begin
                    @(negedge clk);
                    check_eq("stall_valid", out_valid, 1);
                    check_eq("stall_data", out_data, 8'h41);
                    check_eq("stall_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check_eq("stall_n", out_log.size(), 2);
        check_eq("stall_w0", out_log[0], 8'h41);
        check_eq("stall_w1", out_log[1], 8'h02);

        // Full throughput, then check the retained key rotation
        out_log.delete(); acc_cyc.delete();
        msg[0] = 8'h10; msg[1] = 8'h20; msg[2] = 8'h30; msg[3] = 8'h40;
        run_msg(4, 1'b1, 8'h81);
        check_eq("tput_accepts", acc_cyc.size(), 4);
        check_eq("tput_span", acc_cyc[3] - acc_cyc[0], 3);
        check_eq("tput_w3", out_log[3], 8'h4C);
        out_log.delete();
        msg[0] = 8'h00;
        run_msg(1, 1'b0, 8'h00);
        check_eq("rot4_key", out_log[0], 8'h18);

        // Zero-length message
        @(posedge clk);
        #1;
        start = 1'b1; msg_len = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        check_eq("zero_in_ready", in_ready, 0);
        @(negedge clk);
        check_eq("zero_done_end", done, 0);
        check_eq("zero_busy2", busy, 0);
        check_eq("zero_in_ready2", in_ready, 0);

        // Reset mid-message after the first of three words
        @(posedge clk);
        #1;
        key_load = 1'b1; cfg_key = 8'h33; start = 1'b1; msg_len = 8'd3;
        @(posedge clk);
        #1;
        key_load = 1'b0; start = 1'b0;
        in_valid = 1'b1; in_data = 8'h0C;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("pre_rst_cnt", word_cnt, 1);
        check_eq("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_cnt", word_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_idle", busy, 0);
        out_log.delete();
        msg[0] = 8'h5C; msg[1] = 8'hA3;
        run_msg(2, 1'b0, 8'h00);
        check_eq("post_rst_w0", out_log[0], 8'h5C);
        check_eq("post_rst_w1", out_log[1], 8'hA3);

        // start/key_load during RUN are ignored
        out_log.delete(); d0 = done_cnt;
        msg[0] = 8'h00; msg[1] = 8'h00; msg[2] = 8'h00;
        fork
            run_msg(3, 1'b1, 8'h5A);
            begin
                int t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!busy && t < 50);
                @(posedge clk);
                #1;
                start = 1'b1; key_load = 1'b1; cfg_key = 8'hFF; msg_len = 8'd7;
                @(posedge clk);
                #1;
                start = 1'b0; key_load = 1'b0;
            end
        join
        check_eq("ign_n", out_log.size(), 3);
        check_eq("ign_w0", out_log[0], 8'h5A);
        check_eq("ign_w1", out_log[1], 8'hB4);
        check_eq("ign_w2", out_log[2], 8'h69);
        check_eq("ign_done_cnt", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_word_cnt", word_cnt, 3);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/secure_encrypt_ctrl.md
SECURE_ENCRYPT_CTRL -- requirements
Module: secure_encrypt_ctrl

Interface
REQ-001 Parameter: N, default 8, datapath word and key width in bits.
REQ-002 Parameter: LW, default 8, width of the message-length and word-count fields.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_load  input  1  load cfg_key into the key register; honoured only in IDLE.
REQ-006 cfg_key  input  N  key value written by key_load.
REQ-007 start  input  1  begin a message; honoured only in IDLE.
REQ-008 msg_len  input  LW  number of words in the message; sampled on an honoured start.
REQ-009 in_valid  input  1  upstream word valid.
REQ-010 in_data  input  N  upstream plaintext word.
REQ-011 in_ready  output  1  controller accepts in_data this cycle.
REQ-012 out_valid  output  1  out_data holds an encrypted word.
REQ-013 out_data  output  N  encrypted word.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  one-cycle pulse at message completion.
REQ-017 word_cnt  output  LW  words accepted in the current message.

Function
REQ-018 Per-bit transform T(d,k): bit i = 1 when k[i]=1, otherwise bit i = d[i]; result is exactly N bits wide.
REQ-019 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE: start with msg_len>0 -> RUN; word_cnt cleared; remaining count loaded with msg_len.
REQ-021 IDLE: start with msg_len=0 -> DONE directly; no word is accepted.
REQ-022 in_ready = (state==RUN) AND (remaining>0) AND (out_valid=0 OR out_ready=1).
REQ-023 Accept occurs when in_valid AND in_ready: out_data <= T(in_data, key_reg) and out_valid <= 1 on that edge, giving 1-cycle latency.
REQ-024 On each accept: key_reg rotates left by 1 (bit N-1 -> bit 0), word_cnt increments, remaining decrements.
REQ-025 Output handshake: out_valid and out_data hold stable until out_valid AND out_ready; out_valid then clears unless a new accept occurs in the same cycle.
REQ-026 An accept and an output transfer in the same cycle sustain one word per cycle with no bubble.
REQ-027 RUN -> DRAIN on the accept that brings remaining to 0.
REQ-028 DRAIN -> DONE once out_valid=0, or on the cycle its last transfer completes.
REQ-029 DONE: done=1 for exactly one cycle, then -> IDLE; the key_reg rotation is retained.
REQ-030 start, key_load and msg_len are ignored outside IDLE.
REQ-031 A key_load and a start in the same IDLE cycle: the new key is used for the first word.
REQ-032 word_cnt holds its final value after DONE until the next honoured start.
REQ-033 An LW-bit word_cnt never wraps, because msg_len is at most 2^LW-1.

Reset
REQ-034 rst asynchronously forces: state=IDLE, key_reg=0, out_valid=0, out_data=0, in_ready=0, busy=0, done=0, word_cnt=0, remaining=0.
REQ-035 rst mid-message discards any in-flight output word; after release the block waits in IDLE for a new start.

Verification
REQ-036 N=8: key_load 8'h0F, start msg_len=2, in 8'hA0 then 8'h00 with out_ready=1 -> out 8'hAF then 8'h1E; done pulses once; word_cnt=2.
REQ-037 out_ready=0 for 5 cycles with a word pending -> out_valid and out_data stable; in_ready=0; no word is lost or duplicated on release.
REQ-038 Continuous in_valid and out_ready with msg_len=4 -> 4 consecutive accepts in 4 cycles; key after the message is rotated by 4.
REQ-039 start with msg_len=0 -> done pulses the next cycle; in_ready never asserts; busy stays 0.
REQ-040 rst asserted in RUN after 1 of 3 words -> all outputs 0 immediately, state IDLE; a new message runs correctly afterwards with key 0 (out = in).
REQ-041 start and key_load pulsed during RUN -> both ignored; message completes with the original key sequence.
